pwm_duty_feeder: RTL and testbench

PWM_DUTY_FEEDER -- requirements
Module: pwm_duty_feeder

---
 rtl/pwm_duty_feeder.sv | 120 ++++++++++++
 tb/tb_pwm_duty_feeder.sv | 277 +++++++++++++++++++++++++++
 2 files changed

// File: rtl/pwm_duty_feeder.sv
// Duty-cycle feeder: buffers 8-bit duty samples in a small FIFO and hands them
// to a PWM generator only at period boundaries, slew-limited by MAX_STEP.
module pwm_duty_feeder #(
    parameter int PERIOD   = 256,
    parameter int DEPTH    = 4,
    parameter int MAX_STEP = 255
) (
    input  logic                   clk,
    input  logic                   rst_n,
    input  logic [7:0]             s_data,
    input  logic                   s_valid,
    output logic                   s_ready,
    input  logic                   clr_underrun,
    output logic [7:0]             duty_cycle,
    output logic                   period_start,
    output logic                   underrun,
    output logic [$clog2(DEPTH):0] level
);
    localparam int AW = $clog2(DEPTH);
    localparam int LW = AW + 1;
    localparam int CW = $clog2(PERIOD);
    localparam logic [CW-1:0] CNT_LAST = CW'(PERIOD - 1);
    localparam logic [LW-1:0] LVL_FULL = LW'(DEPTH);
    localparam logic [7:0]    STEP_MAX = 8'(MAX_STEP);

    typedef enum logic [1:0] {WAIT_FIRST, RUN, STARVED} state_t;

    state_t        state_q, state_d;
    logic [CW-1:0] cnt_q, cnt_d;
    logic          period_start_q;
    logic [7:0]    duty_q, duty_d;
    logic [7:0]    target_q, target_d;
    logic          underrun_q, underrun_d;
    logic [LW-1:0] level_q, level_d;
    logic [AW-1:0] wr_ptr_q, rd_ptr_q;
    logic [7:0]    mem_q [DEPTH];

    logic boundary, push, pop, starve;

    // Move cur toward tgt by at most MAX_STEP; magnitude is taken first so
    // the step never wraps through 0 or 255.
    function automatic logic [7:0] slew(input logic [7:0] cur, input logic [7:0] tgt);
        logic [7:0] diff;
        diff = (tgt >= cur) ? (tgt - cur) : (cur - tgt);
        if (diff > STEP_MAX) diff = STEP_MAX;
        return (tgt >= cur) ? (cur + diff) : (cur - diff);
    endfunction

    always_comb begin
        boundary = (cnt_q == CNT_LAST);
        s_ready  = rst_n && (level_q != LVL_FULL);
        push     = s_valid && s_ready;
        pop      = boundary && (duty_q == target_q) && (level_q != '0);
    end

    always_comb begin
        state_d    = state_q;
        underrun_d = underrun_q;
        starve     = 1'b0;
        case (state_q)
            WAIT_FIRST: if (pop) state_d = RUN;
            RUN: begin
                if (boundary && (duty_q == target_q) && (level_q == '0)) begin
                    state_d = STARVED;
                    starve  = 1'b1;
                end
            end
            STARVED: if (pop) state_d = RUN;
            default: state_d = WAIT_FIRST;
        endcase
        if (starve) underrun_d = 1'b1;
        else if (clr_underrun) underrun_d = 1'b0;
    end

    // A freshly popped sample is slewed toward in the same boundary cycle.
    always_comb begin
        target_d = pop ? mem_q[rd_ptr_q] : target_q;
        duty_d   = boundary ? slew(duty_q, target_d) : duty_q;
        cnt_d    = boundary ? '0 : cnt_q + CW'(1);
        case ({push, pop})
            2'b10:   level_d = level_q + LW'(1);
            2'b01:   level_d = level_q - LW'(1);
            default: level_d = level_q;
        endcase
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_q        <= WAIT_FIRST;
            cnt_q          <= '0;
            period_start_q <= 1'b0;
            duty_q         <= '0;
            target_q       <= '0;
            underrun_q     <= 1'b0;
            level_q        <= '0;
            wr_ptr_q       <= '0;
            rd_ptr_q       <= '0;
        end else begin
            state_q        <= state_d;
            cnt_q          <= cnt_d;
            period_start_q <= (cnt_q == '0);
            duty_q         <= duty_d;
            target_q       <= target_d;
            underrun_q     <= underrun_d;
            level_q        <= level_d;
            wr_ptr_q       <= push ? wr_ptr_q + AW'(1) : wr_ptr_q;
            rd_ptr_q       <= pop ? rd_ptr_q + AW'(1) : rd_ptr_q;
        end
    end

    always_ff @(posedge clk) begin
        if (push) mem_q[wr_ptr_q] <= s_data;
    end

    assign duty_cycle   = duty_q;
    assign period_start = period_start_q;
    assign underrun     = underrun_q;
    assign level        = level_q;

endmodule

// File: tb/tb_pwm_duty_feeder.sv
// Bench for pwm_duty_feeder: two instances (MAX_STEP 255 and 16) share one
// directed stimulus and are checked every cycle against a queue-level model.
module tb_pwm_duty_feeder;
    localparam int PERIOD = 16;
    localparam int DEPTH  = 4;
    localparam int P_WAIT = 0, P_RUN = 1, P_STARVED = 2;

    logic       clk, rst_n, s_valid, clr_underrun;
    logic [7:0] s_data;
    logic       rdy_a, rdy_b, ps_a, ps_b, unr_a, unr_b;
    logic [7:0] duty_a, duty_b;
    logic [2:0] lvl_a, lvl_b;

    int checks = 0;
    int failures = 0;

    pwm_duty_feeder #(.PERIOD(PERIOD), .DEPTH(DEPTH), .MAX_STEP(255)) dut_a (
        .clk(clk), .rst_n(rst_n), .s_data(s_data), .s_valid(s_valid), .s_ready(rdy_a),
        .clr_underrun(clr_underrun), .duty_cycle(duty_a), .period_start(ps_a),
        .underrun(unr_a), .level(lvl_a));

    pwm_duty_feeder #(.PERIOD(PERIOD), .DEPTH(DEPTH), .MAX_STEP(16)) dut_b (
        .clk(clk), .rst_n(rst_n), .s_data(s_data), .s_valid(s_valid), .s_ready(rdy_b),
        .clr_underrun(clr_underrun), .duty_cycle(duty_b), .period_start(ps_b),
        .underrun(unr_b), .level(lvl_b));

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    // Behavioural model: per-instance duty/target, a shift-on-pop sample list.
    int         m_pos, m_ps;
    int         m_duty [2], m_tgt [2], m_lvl [2], m_phase [2], m_unr [2];
    int         m_ms [2] = '{255, 16};
    logic [7:0] m_fifo [2][DEPTH];
    bit         model_ok = 1'b0;
    bit         m_push, m_set;

    function automatic int approach(int cur, int tgt, int ms);
        int d;
        d = tgt - cur;
        if (d > ms) d = ms;
        if (d < -ms) d = -ms;
        return cur + d;
    endfunction

    always @(posedge clk) begin
        if (!rst_n) begin
            m_pos = 0;
            m_ps  = 0;
            for (int k = 0; k < 2; k++) begin
                m_duty[k] = 0; m_tgt[k] = 0; m_lvl[k] = 0; m_phase[k] = P_WAIT; m_unr[k] = 0;
            end
            model_ok = 1'b1;
        end else begin
            for (int k = 0; k < 2; k++) begin
                m_push = s_valid && (m_lvl[k] < DEPTH);
                m_set  = 1'b0;
                if (m_pos == PERIOD - 1) begin
                    if (m_duty[k] != m_tgt[k]) begin
                        m_duty[k] = approach(m_duty[k], m_tgt[k], m_ms[k]);
                    end else if (m_lvl[k] > 0) begin
                        m_tgt[k] = int'(m_fifo[k][0]);
                        for (int j = 0; j < DEPTH - 1; j++) m_fifo[k][j] = m_fifo[k][j+1];
                        m_lvl[k]   = m_lvl[k] - 1;
                        m_phase[k] = P_RUN;
                        m_duty[k]  = approach(m_duty[k], m_tgt[k], m_ms[k]);
                    end else if (m_phase[k] == P_RUN) begin
                        m_phase[k] = P_STARVED;
                        m_set      = 1'b1;
                    end
                end
                if (m_set) m_unr[k] = 1;
                else if (clr_underrun) m_unr[k] = 0;
                if (m_push) begin
                    m_fifo[k][m_lvl[k]] = s_data;
                    m_lvl[k] = m_lvl[k] + 1;
                end
            end
            m_ps  = (m_pos == 0) ? 1 : 0;
            m_pos = (m_pos + 1) % PERIOD;
        end
    end

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s at %0t: got %0h expected %0h", name, $time, act, exp);
        end
    endtask

    always @(negedge clk) begin
        if (model_ok) begin
            chk("A.duty", duty_a, m_duty[0]);
            chk("A.level", lvl_a, m_lvl[0]);
            chk("A.underrun", unr_a, m_unr[0]);
            chk("A.period_start", ps_a, m_ps);
            chk("A.s_ready", rdy_a, (rst_n && m_lvl[0] < DEPTH) ? 1 : 0);
            chk("B.duty", duty_b, m_duty[1]);
            chk("B.level", lvl_b, m_lvl[1]);
            chk("B.underrun", unr_b, m_unr[1]);
            chk("B.period_start", ps_b, m_ps);
            chk("B.s_ready", rdy_b, (rst_n && m_lvl[1] < DEPTH) ? 1 : 0);
        end
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic goto_pos(input int p);
        int n;
        n = 0;
        do begin
            tick();
            n++;
        end while (m_pos != p && n <= PERIOD + 1);
        if (m_pos != p) begin
            checks++;
            failures++;
            $display("FAIL goto_pos: position %0d not reached, at %0d", p, m_pos);
        end
    endtask

    task automatic push(input logic [7:0] v);
        s_valid = 1'b1;
        s_data  = v;
        tick();
        s_valid = 1'b0;
    endtask

    initial begin
        rst_n = 1'b0; s_valid = 1'b0; s_data = 8'h00; clr_underrun = 1'b0;
        repeat (3) tick();
        chk("rst.duty", duty_a, 8'h00);
        chk("rst.level", lvl_a, 3'd0);
        chk("rst.underrun", unr_a, 1'b0);
        chk("rst.period_start", ps_a, 1'b0);
        chk("rst.s_ready", rdy_a, 1'b0);
        rst_n = 1'b1;
        #1;
        chk("rel.s_ready", rdy_a, 1'b1);

        // First sample: pushed at cycle 3, shown at the next period start.
        tick();
        chk("rel.period_start", ps_a, 1'b1);
        tick();
        push(8'h80);
        chk("first.level", lvl_a, 3'd1);
        goto_pos(PERIOD - 1);
        chk("first.hold", duty_a, 8'h00);
        goto_pos(0);
        chk("first.dutyA", duty_a, 8'h80);
        chk("first.dutyB", duty_b, 8'h10);
        chk("first.underrun", unr_a, 1'b0);

        // Fill to full; fifth sample held until a boundary pop frees a slot.
        goto_pos(1);
        push(8'h90); push(8'hA0); push(8'hB0); push(8'hC0);
        chk("full.level", lvl_a, 3'd4);
        chk("full.s_ready", rdy_a, 1'b0);
        s_valid = 1'b1;
        s_data  = 8'hD0;
        goto_pos(PERIOD - 1);
        chk("full.held", lvl_a, 3'd4);
        goto_pos(0);
        chk("full.pop_level", lvl_a, 3'd3);
        chk("full.pop_duty", duty_a, 8'h90);
        chk("full.ready_again", rdy_a, 1'b1);
        tick();
        s_valid = 1'b0;
        chk("full.fifth_in", lvl_a, 3'd4);

        // Push and pop in the same boundary cycle at level 2.
        goto_pos(0);
        chk("drain.A0", duty_a, 8'hA0);
        goto_pos(0);
        chk("drain.B0", duty_a, 8'hB0);
        goto_pos(PERIOD - 1);
        chk("pp.level_before", lvl_a, 3'd2);
        push(8'hE0);
        chk("pp.level_after", lvl_a, 3'd2);
        chk("pp.C0", duty_a, 8'hC0);
        goto_pos(0);
        chk("pp.D0", duty_a, 8'hD0);
        goto_pos(0);
        chk("pp.E0", duty_a, 8'hE0);
        chk("pp.no_underrun", unr_a, 1'b0);

        // Starvation, recovery, sticky flag and clear priority.
        goto_pos(0);
        chk("starve.underrun", unr_a, 1'b1);
        chk("starve.hold", duty_a, 8'hE0);
        goto_pos(2);
        push(8'h22);
        goto_pos(0);
        chk("recover.duty", duty_a, 8'h22);
        chk("recover.sticky", unr_a, 1'b1);
        clr_underrun = 1'b1;
        tick();
        clr_underrun = 1'b0;
        chk("clr.underrun", unr_a, 1'b0);
        goto_pos(PERIOD - 1);
        clr_underrun = 1'b1;
        tick();
        clr_underrun = 1'b0;
        chk("prio.set_wins", unr_a, 1'b1);

        // Mid-operation reset, then slew-limited stepping on instance B.
        rst_n = 1'b0;
        tick();
        rst_n = 1'b1;
        chk("rst2.levelB", lvl_b, 3'd0);
        goto_pos(2);
        push(8'h10);
        goto_pos(0);
        chk("slew.start", duty_b, 8'h10);
        goto_pos(2);
        push(8'h50);
        push(8'h60);
        goto_pos(0);
        chk("slew.20", duty_b, 8'h20);
        chk("slew.A50", duty_a, 8'h50);
        chk("slew.lvl1", lvl_b, 3'd1);
        goto_pos(0);
        chk("slew.30", duty_b, 8'h30);
        chk("slew.lvl2", lvl_b, 3'd1);
        goto_pos(0);
        chk("slew.40", duty_b, 8'h40);
        goto_pos(0);
        chk("slew.50", duty_b, 8'h50);
        chk("slew.no_pop", lvl_b, 3'd1);
        goto_pos(0);
        chk("slew.60", duty_b, 8'h60);
        chk("slew.popped", lvl_b, 3'd0);

        // Downward step must not wrap: 250 toward 5 by 16 gives 234.
        goto_pos(2);
        push(8'hFA);
        repeat (10) goto_pos(0);
        chk("wrap.at250", duty_b, 8'hFA);
        goto_pos(2);
        push(8'h05);
        goto_pos(0);
        chk("wrap.234", duty_b, 8'hEA);
        chk("wrap.A05", duty_a, 8'h05);

        // Reset with level 3 and duty 0x40 returns to WAIT_FIRST.
        goto_pos(2);
        push(8'h40);
        goto_pos(0);
        chk("r36.duty40", duty_a, 8'h40);
        goto_pos(2);
        push(8'h41); push(8'h42); push(8'h43);
        chk("r36.level3", lvl_a, 3'd3);
        chk("r36.underrun_pre", unr_a, 1'b1);
        rst_n = 1'b0;
        tick();
        rst_n = 1'b1;
        chk("r36.level", lvl_a, 3'd0);
        chk("r36.duty", duty_a, 8'h00);
        chk("r36.underrun", unr_a, 1'b0);
        chk("r36.dutyB", duty_b, 8'h00);
        tick();
        chk("r36.period_start", ps_a, 1'b1);
        goto_pos(0);
        chk("r36.wait_no_underrun", unr_a, 1'b0);
        chk("r36.wait_duty", duty_a, 8'h00);

        tick();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule
